// File: rtl/game_round_controller_if.sv
// Player-input / round-status bundle for game_round_controller.
// The master drives the pulse inputs; the controller is the slave.
interface game_round_controller_if;
  logic       Start;
  logic       Pause;
  logic       Bonus;
  logic [2:0] State;
  logic [3:0] OnesDigit;
  logic [3:0] TensDigit;
  logic       SecondTick;
  logic       GameActive;
  logic       Done;

  modport master (
    output Start, Pause, Bonus,
    input  State, OnesDigit, TensDigit,
    input  SecondTick, GameActive, Done
  );

  modport slave (
    input  Start, Pause, Bonus,
    output State, OnesDigit, TensDigit,
    output SecondTick, GameActive, Done
  );
endinterface

// File: rtl/game_round_controller.sv
// Round sequencer: idle, countdown, timed play, pause, game-over.
// Define ROUND_BONUS_EN to let Bonus add BONUS_SECONDS while playing.
module game_round_controller #(
  parameter int CLOCK_FREQUENCY  = 50000000,
  parameter int ROUND_SECONDS    = 60,
  parameter int PRESTART_SECONDS = 3,
  parameter int BONUS_SECONDS    = 5
) (
  input  logic                   Clock,
  input  logic                   Reset,
  game_round_controller_if.slave bus
);
  localparam int DW = $clog2(CLOCK_FREQUENCY);
  localparam logic [DW-1:0] RELOAD = DW'(CLOCK_FREQUENCY - 1);
  localparam logic [3:0] ROUND_T = 4'(ROUND_SECONDS / 10);
  localparam logic [3:0] ROUND_O = 4'(ROUND_SECONDS % 10);
  localparam logic [3:0] PRE_O   = 4'(PRESTART_SECONDS);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PRE   = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic          tick_q, tick_d;
  logic          active_q, active_d;
  logic          done_q, done_d;

  logic       counting, tick, last;
  logic [3:0] dec_t, dec_o, base_t, base_o;
  logic [3:0] play_t, play_o;
  logic       bonus_hit;

  always_comb begin
    counting = (state_q == ST_PRE) || (state_q == ST_PLAY);
    tick     = counting && (div_q == '0);
    last     = (tens_q == 4'd0) && (ones_q == 4'd1);
    if (ones_q != 4'd0) begin
      dec_t = tens_q;
      dec_o = ones_q - 4'd1;
    end else begin
      dec_t = (tens_q == 4'd0) ? 4'd0 : tens_q - 4'd1;
      dec_o = 4'd9;
    end
    base_t = tick ? dec_t : tens_q;
    base_o = tick ? dec_o : ones_q;
  end

`ifdef ROUND_BONUS_EN
  localparam logic [4:0] BONUS = 5'(BONUS_SECONDS);
  logic [4:0] sum_t, sum_o;

  // BCD add on the post-tick value, clamped to 99
  always_comb begin
    bonus_hit = bus.Bonus && (state_q == ST_PLAY);
    sum_o     = {1'b0, base_o} + BONUS;
    sum_t     = {1'b0, base_t};
    if (sum_o > 5'd9) begin
      sum_o = sum_o - 5'd10;
      sum_t = sum_t + 5'd1;
    end
    if (!bonus_hit) begin
      play_t = base_t;
      play_o = base_o;
    end else if (sum_t > 5'd9) begin
      play_t = 4'd9;
      play_o = 4'd9;
    end else begin
      play_t = sum_t[3:0];
      play_o = sum_o[3:0];
    end
  end
`else
  assign bonus_hit = 1'b0;
  assign play_t    = base_t;
  assign play_o    = base_o;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.Start) state_d = ST_PRE;
      ST_PRE:   if (tick && last) state_d = ST_PLAY;
      ST_PLAY: begin
        if (tick && last && !bonus_hit) state_d = ST_OVER;
        else if (bus.Pause)            state_d = ST_PAUSE;
      end
      ST_PAUSE: if (bus.Pause) state_d = ST_PLAY;
      ST_OVER:  if (bus.Start) state_d = ST_PRE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    div_d    = div_q;
    tens_d   = tens_q;
    ones_d   = ones_q;
    tick_d   = tick;
    done_d   = 1'b0;
    active_d = (state_d == ST_PLAY);
    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        tens_d = 4'd0;
        ones_d = 4'd0;
        if (bus.Start) begin
          div_d  = RELOAD;
          ones_d = PRE_O;
        end
      end
      ST_PRE: begin
        div_d = tick ? RELOAD : div_q - 1'b1;
        if (tick) begin
          tens_d = last ? ROUND_T : dec_t;
          ones_d = last ? ROUND_O : dec_o;
        end
      end
      ST_PLAY: begin
        div_d  = tick ? RELOAD : div_q - 1'b1;
        tens_d = play_t;
        ones_d = play_o;
        if (tick && last && !bonus_hit) begin
          tens_d = 4'd0;
          ones_d = 4'd0;
          done_d = 1'b1;
        end
      end
      ST_PAUSE: ;
      default: begin
        div_d  = RELOAD;
        tens_d = 4'd0;
        ones_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      div_q    <= RELOAD;
      tens_q   <= 4'd0;
      ones_q   <= 4'd0;
      tick_q   <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      tick_q   <= tick_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign bus.State      = state_q;
  assign bus.TensDigit  = tens_q;
  assign bus.OnesDigit  = ones_q;
  assign bus.SecondTick = tick_q;
  assign bus.GameActive = active_q;
  assign bus.Done       = done_q;
endmodule

// File: tb/tb_game_round_controller.sv
// Directed bench for game_round_controller (CLOCK_FREQUENCY=4).
// Bonus expectations follow ROUND_BONUS_EN when it is defined.
module tb_game_round_controller;
  logic Clock = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  always #5 Clock = ~Clock;

  game_round_controller_if bus ();

  game_round_controller #(
    .CLOCK_FREQUENCY (4),
    .ROUND_SECONDS   (12),
    .PRESTART_SECONDS(3),
    .BONUS_SECONDS   (5)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  typedef struct {
    logic       rst;
    logic       st;
    logic       pa;
    logic       bo;
    int         n;
    logic [2:0] state;
    logic [7:0] dig;
    logic       tick;
    logic       act;
    logic       done;
  } vec_t;

  vec_t vt [0:63];
  int   nv = 0;

  task automatic add(input logic r, s, p, b, input int n,
                     input logic [2:0] st, input logic [7:0] d,
                     input logic t, a, dn);
    vt[nv] = '{r, s, p, b, n, st, d, t, a, dn};
    nv++;
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] st,
                       input logic [7:0] d, input logic t, a, dn);
    logic [14:0] got, exp;
    got = {bus.State, bus.TensDigit, bus.OnesDigit,
           bus.SecondTick, bus.GameActive, bus.Done};
    exp = {st, d, t, a, dn};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got state=%0d digits=%h tick=%b act=%b done=%b, want state=%0d digits=%h tick=%b act=%b done=%b",
               name, bus.State, {bus.TensDigit, bus.OnesDigit},
               bus.SecondTick, bus.GameActive, bus.Done, st, d, t, a, dn);
    end
  endtask

  task automatic wait_tick(input string name, input logic [7:0] d,
                           input int max);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < max && !ok; k++) begin
      cyc();
      if (bus.SecondTick && bus.State == 3'd2 &&
          {bus.TensDigit, bus.OnesDigit} == d)
        ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: no tick to digits=%h in %0d cycles, got digits=%h",
               name, d, max, {bus.TensDigit, bus.OnesDigit});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1;
    bus.Start = 1'b0;
    bus.Pause = 1'b0;
    bus.Bonus = 1'b0;

    //   rst st pa bo  n  state dig  tk ac dn
    add(1, 0, 0, 0,  1, 0, 8'h00, 0, 0, 0);
    add(0, 1, 0, 0,  1, 1, 8'h03, 0, 0, 0);
    add(0, 0, 0, 0,  4, 1, 8'h02, 1, 0, 0);
    add(0, 0, 0, 0,  4, 1, 8'h01, 1, 0, 0);
    add(0, 0, 0, 0,  4, 2, 8'h12, 1, 1, 0);
    add(0, 0, 0, 0,  1, 2, 8'h12, 0, 1, 0);
    add(0, 1, 0, 0,  3, 2, 8'h11, 1, 1, 0);
    add(0, 0, 0, 0,  4, 2, 8'h10, 1, 1, 0);
    add(0, 0, 0, 0,  4, 2, 8'h09, 1, 1, 0);
    add(0, 0, 0, 0,  1, 2, 8'h09, 0, 1, 0);
    add(0, 0, 1, 0,  1, 3, 8'h09, 0, 0, 0);
    add(0, 0, 0, 0, 20, 3, 8'h09, 0, 0, 0);
    add(0, 1, 0, 0,  1, 3, 8'h09, 0, 0, 0);
    add(0, 0, 0, 1,  1, 3, 8'h09, 0, 0, 0);
    add(0, 0, 1, 0,  1, 2, 8'h09, 0, 1, 0);
    add(0, 0, 0, 0,  1, 2, 8'h09, 0, 1, 0);
    add(0, 0, 0, 0,  1, 2, 8'h08, 1, 1, 0);
    add(0, 0, 0, 0,  4, 2, 8'h07, 1, 1, 0);
    add(0, 0, 0, 0,  4, 2, 8'h06, 1, 1, 0);
    add(0, 0, 0, 0,  4, 2, 8'h05, 1, 1, 0);
    add(0, 0, 0, 0,  3, 2, 8'h05, 0, 1, 0);
    add(0, 0, 1, 0,  1, 3, 8'h04, 1, 0, 0);
    add(0, 0, 0, 0,  3, 3, 8'h04, 0, 0, 0);
    add(0, 0, 1, 0,  1, 2, 8'h04, 0, 1, 0);
    add(0, 0, 0, 0,  4, 2, 8'h03, 1, 1, 0);
    add(0, 0, 0, 0,  8, 2, 8'h01, 1, 1, 0);
    add(0, 0, 0, 0,  3, 2, 8'h01, 0, 1, 0);
    add(0, 0, 1, 0,  1, 4, 8'h00, 1, 0, 1);
    add(0, 0, 0, 0,  1, 4, 8'h00, 0, 0, 0);
    add(0, 0, 1, 0,  1, 4, 8'h00, 0, 0, 0);
    add(0, 1, 0, 0,  1, 1, 8'h03, 0, 0, 0);
    add(0, 0, 0, 0,  2, 1, 8'h03, 0, 0, 0);
    add(0, 1, 0, 0,  1, 1, 8'h03, 0, 0, 0);
    add(0, 0, 0, 0,  1, 1, 8'h02, 1, 0, 0);
    add(1, 0, 0, 0,  1, 0, 8'h00, 0, 0, 0);
    add(0, 0, 1, 0,  1, 0, 8'h00, 0, 0, 0);
    add(0, 0, 0, 1,  1, 0, 8'h00, 0, 0, 0);
    add(0, 1, 0, 0,  1, 1, 8'h03, 0, 0, 0);
    add(0, 0, 0, 0, 12, 2, 8'h12, 1, 1, 0);
    add(0, 0, 0, 0,  2, 2, 8'h12, 0, 1, 0);
    add(0, 0, 1, 0,  1, 3, 8'h12, 0, 0, 0);
    add(1, 0, 0, 0,  1, 0, 8'h00, 0, 0, 0);

    cyc();
    cyc();
    for (int i = 0; i < nv; i++) begin
      Reset     = vt[i].rst;
      bus.Start = vt[i].st;
      bus.Pause = vt[i].pa;
      bus.Bonus = vt[i].bo;
      cyc();
      Reset     = 1'b0;
      bus.Start = 1'b0;
      bus.Pause = 1'b0;
      bus.Bonus = 1'b0;
      repeat (vt[i].n - 1) cyc();
      check($sformatf("vec%0d", i), vt[i].state, vt[i].dig,
            vt[i].tick, vt[i].act, vt[i].done);
    end

    // Bonus mid-second at 07, then coincident with the terminal tick
    bus.Start = 1'b1;
    cyc();
    bus.Start = 1'b0;
    wait_tick("reach_07", 8'h07, 200);
    cyc();
    bus.Bonus = 1'b1;
    cyc();
    bus.Bonus = 1'b0;
`ifdef ROUND_BONUS_EN
    check("bonus_07", 3'd2, 8'h12, 1'b0, 1'b1, 1'b0);
`else
    check("bonus_07", 3'd2, 8'h07, 1'b0, 1'b1, 1'b0);
`endif
    wait_tick("reach_01", 8'h01, 100);
    repeat (3) cyc();
    bus.Bonus = 1'b1;
    cyc();
    bus.Bonus = 1'b0;
`ifdef ROUND_BONUS_EN
    check("bonus_term", 3'd2, 8'h05, 1'b1, 1'b1, 1'b0);
`else
    check("bonus_term", 3'd4, 8'h00, 1'b1, 1'b0, 1'b1);
`endif
    bus.Bonus = 1'b1;
    repeat (30) cyc();
    bus.Bonus = 1'b0;
`ifdef ROUND_BONUS_EN
    check("bonus_sat", 3'd2, 8'h99, 1'b0, 1'b1, 1'b0);
`else
    check("bonus_sat", 3'd4, 8'h00, 1'b0, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/game_round_controller.md
Name: game_round_controller

Overview:
Sequences one game round: idle, a short pre-start countdown, the timed play phase, pause/resume, and game-over.
Contains its own one-second rate divider and a two-digit BCD down-counter, so the HEX display and the game logic share one timing source.
Sits between the player-facing switch/key inputs and the spawner/scoring logic, which it gates through GameActive.

Parameters:
CLOCK_FREQUENCY, 50000000, Clock cycles per second tick; legal range 2..2^27.
ROUND_SECONDS, 60, round length in seconds; legal range 1..99; loaded as BCD.
PRESTART_SECONDS, 3, pre-start countdown length in seconds; legal range 1..9.
BONUS_SECONDS, 5, seconds added per Bonus pulse; legal range 1..9; only used with ROUND_BONUS_EN.

Ports:
Clock  in  1  system clock.
Reset  in  1  synchronous, active-high.
Start  in  1  one-cycle pulse; begins a round from IDLE or OVER.
Pause  in  1  one-cycle pulse; toggles PLAYING and PAUSED.
Bonus  in  1  one-cycle pulse; extends the round (optional feature only).
State  out  3  IDLE=0, PRESTART=1, PLAYING=2, PAUSED=3, OVER=4.
OnesDigit  out  4  BCD ones digit of the remaining time.
TensDigit  out  4  BCD tens digit of the remaining time.
SecondTick  out  1  one-cycle pulse on every applied second tick.
GameActive  out  1  high only while State==PLAYING.
Done  out  1  one-cycle pulse when the round expires.

Behaviour:
- All outputs are registered.
- Reset values: State=IDLE, digits=00, SecondTick=0, GameActive=0, Done=0, divider=CLOCK_FREQUENCY-1.
- Reset has priority over every other input. Reset mid-round returns the block to IDLE on the next edge.
- Divider:
  - Reloads to CLOCK_FREQUENCY-1 on every entry into PRESTART or PLAYING from IDLE/OVER/PRESTART.
  - Decrements only in PRESTART and PLAYING.
  - In PAUSED it holds its value, so a resume continues the partial second.
  - A tick occurs on the edge where divider==0 and the state is counting; the divider reloads on that same edge.
  - Ticks therefore occur every CLOCK_FREQUENCY cycles. SecondTick is high for the cycle after the tick edge.
- BCD down-count on each tick:
  - If ones!=0, ones-1.
  - Else ones=9 and tens-1.
  - Digits never leave the 0..9 range.
- IDLE: Start -> PRESTART, digits={0,PRESTART_SECONDS}. Pause and Bonus are ignored.
- PRESTART:
  - Tick with digits==01 -> PLAYING, digits=BCD(ROUND_SECONDS).
  - Other ticks decrement the digits.
  - Pause, Start and Bonus are ignored.
- PLAYING:
  - Tick with digits==01 -> OVER, digits=00, Done=1 for one cycle.
  - Other ticks decrement the digits.
  - Pause -> PAUSED.
  - Start is ignored.
- PAUSED: Pause -> PLAYING. Start and Bonus are ignored. Digits and divider are frozen.
- OVER: digits hold 00. Start -> PRESTART as from IDLE. Pause is ignored.
- Simultaneous events in PLAYING:
  - Tick+Pause: the decrement is applied and the state becomes PAUSED.
  - Terminal tick+Pause: OVER wins and Pause is dropped.
- Latency: Start sampled at edge k -> State=PRESTART and digits=03 visible after edge k; the first tick occurs at edge k+CLOCK_FREQUENCY.
- GameActive is registered with the state, so it rises on the same edge State becomes PLAYING.
- Unused State encodings 5..7 recover to IDLE on the next edge.

Optional Feature:
ROUND_BONUS_EN.
- Defined:
  - A Bonus pulse in PLAYING adds BONUS_SECONDS to the digits using BCD addition, saturating at 99.
  - Bonus is ignored in all other states.
  - Bonus+tick in the same cycle: the net result is digits-1+BONUS_SECONDS. If that tick is terminal (digits==01), the bonus is applied instead, the state stays PLAYING, and Done is not asserted.
- Undefined: the Bonus port exists but is ignored, and no adder logic is synthesised.

Test Plan:
All scenarios use CLOCK_FREQUENCY=4, ROUND_SECONDS=12, PRESTART_SECONDS=3.
1. Reset, then pulse Start -> State=1 and digits 03; digits go 02, 01 at 4-cycle spacing; the next tick gives State=2, digits 12, GameActive=1.
2. Run PLAYING to completion -> digits 12,11,10,09,...,01, then State=4, digits 00, Done high for exactly one cycle, GameActive=0; a later Start gives State=1, digits 03.
3. Pause 2 cycles after a tick at digits 10 -> State=3 and digits stay 10 for 20 cycles; Pause again -> the next tick arrives 2 cycles later with digits 09.
4. Pause coincident with the tick at digits 05 -> digits 04, State=3. Pause coincident with the terminal tick -> State=4, Done=1.
5. With ROUND_BONUS_EN, Bonus at digits 96 (ROUND_SECONDS=97) -> digits 99. Bonus at 07 -> 12. Bonus coincident with terminal tick at 01 -> digits 05, State=2, no Done.
6. Reset asserted in PAUSED and in PRESTART -> next edge State=0, digits 00, all pulses 0; Start in PRESTART/PAUSED has no effect.
